// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key event decoder.
// Timing defaults assume the 50 MHz system clock.
package key_pkg;

   localparam int CNT_W = 26;

   localparam int LONG_CNT_DEF   = 50_000_000;
   localparam int DCLK_CNT_DEF   = 15_000_000;
   localparam int REPEAT_CNT_DEF = 5_000_000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      LONG   = 3'd4
   } key_state_t;

endpackage

// File: rtl/key_edge_det.sv
// Press/release edge detector for an active-low debounced key level.
// Reset value 1 makes a key held through reset appear as a fresh press.
module key_edge_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_press,
   output logic o_release
);

   logic r_key_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_key_d <= 1'b1;
      end else begin
         r_key_d <= i_key;
      end
   end

   assign o_press   = r_key_d & ~i_key;
   assign o_release = ~r_key_d & i_key;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies a debounced key into short/double/long events and long hold.
// Define KEY_REPEAT_EN to enable auto-repeat pulses while in long hold.
module key_event_decoder
   import key_pkg::*;
#(
   parameter int               CNT_W    = key_pkg::CNT_W,
   parameter logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CNT_DEF),
   parameter logic [CNT_W-1:0] DCLK_CNT = CNT_W'(DCLK_CNT_DEF)
`ifdef KEY_REPEAT_EN
   ,
   parameter logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_CNT_DEF)
`endif
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_filter,
   output logic short_press,
   output logic double_click,
   output logic long_press,
   output logic key_repeat,
   output logic long_hold
);

   localparam logic [CNT_W-1:0] L_LONG_TC = LONG_CNT - 1'b1;
   localparam logic [CNT_W-1:0] L_DCLK_TC = DCLK_CNT - 1'b1;
`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] L_REP_TC  = REPEAT_CNT - 1'b1;
`endif

   key_state_t       r_state;
   key_state_t       w_nxt_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_press;
   logic             w_release;
   logic             w_sp;
   logic             w_dc;
   logic             w_lp;
   logic             w_rp;
   logic             r_sp;
   logic             r_dc;
   logic             r_lp;
   logic             r_rp;

   key_edge_det u_edge (
      .i_clk     (sys_clk),
      .i_rst_n   (sys_rst_n),
      .i_key     (key_filter),
      .o_press   (w_press),
      .o_release (w_release)
   );

   // Key edges are tested before terminal counts so an edge always wins.
   always_comb begin
      w_nxt_state = r_state;
      w_sp        = 1'b0;
      w_dc        = 1'b0;
      w_lp        = 1'b0;
      w_rp        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press) w_nxt_state = PRESS1;
         end
         PRESS1: begin
            if (w_release) begin
               w_nxt_state = WAIT2;
            end else if (r_cnt == L_LONG_TC) begin
               w_nxt_state = LONG;
               w_lp        = 1'b1;
            end
         end
         WAIT2: begin
            if (w_press) begin
               w_nxt_state = PRESS2;
            end else if (r_cnt == L_DCLK_TC) begin
               w_nxt_state = IDLE;
               w_sp        = 1'b1;
            end
         end
         PRESS2: begin
            if (w_release) begin
               w_nxt_state = IDLE;
               w_dc        = 1'b1;
            end else if (r_cnt == L_LONG_TC) begin
               w_nxt_state = LONG;
               w_lp        = 1'b1;
            end
         end
         LONG: begin
            if (w_release) begin
               w_nxt_state = IDLE;
            end
`ifdef KEY_REPEAT_EN
            else if (r_cnt == L_REP_TC) begin
               w_rp = 1'b1;
            end
`endif
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   always_comb begin
      w_cnt_nxt = '0;
      if (w_nxt_state == r_state && !w_rp) begin
         case (r_state)
            PRESS1, WAIT2, PRESS2: w_cnt_nxt = r_cnt + 1'b1;
`ifdef KEY_REPEAT_EN
            LONG:                  w_cnt_nxt = r_cnt + 1'b1;
`endif
            default:               w_cnt_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sp    <= 1'b0;
         r_dc    <= 1'b0;
         r_lp    <= 1'b0;
         r_rp    <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_cnt_nxt;
         r_sp    <= w_sp;
         r_dc    <= w_dc;
         r_lp    <= w_lp;
         r_rp    <= w_rp;
      end
   end

   assign short_press  = r_sp;
   assign double_click = r_dc;
   assign long_press   = r_lp;
   assign key_repeat   = r_rp;
   assign long_hold    = (r_state == LONG);

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench: timestamp-based reference model vs key_event_decoder.
// Short timing overrides keep every scenario to a few dozen cycles.
module tb_key_event_decoder;

   localparam int T_LONG = 20;
   localparam int T_DCLK = 10;
   localparam int T_REP  = 4;
`ifdef KEY_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   localparam logic [3:0] EV_SP = 4'b0001;
   localparam logic [3:0] EV_DC = 4'b0010;
   localparam logic [3:0] EV_LP = 4'b0100;
   localparam logic [3:0] EV_RP = 4'b1000;

   typedef struct {
      int         cyc;
      logic [3:0] ev;
   } exp_t;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic key_filter = 1'b1;
   logic short_press;
   logic double_click;
   logic long_press;
   logic key_repeat;
   logic long_hold;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   exp_hold = 1'b0;

   always #5 sys_clk = ~sys_clk;

   key_event_decoder #(
      .LONG_CNT   (26'd20),
      .DCLK_CNT   (26'd10)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_CNT (26'd4)
`endif
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .key_filter   (key_filter),
      .short_press  (short_press),
      .double_click (double_click),
      .long_press   (long_press),
      .key_repeat   (key_repeat),
      .long_hold    (long_hold)
   );

   function automatic void push_ev(input int c, input logic [3:0] e);
      exp_t x;
      x.cyc = c;
      x.ev  = e;
      sb.push_back(x);
   endfunction

   // Reference: phase of the user gesture plus the cycle it started at.
   // Decisions come from elapsed cycles since the last key edge.
   initial begin : model
      int  phase;
      int  t0;
      bit  prev;
      bit  k;
      bit  pr;
      bit  rl;
      phase = 0;
      t0    = 0;
      prev  = 1'b1;
      forever begin
         @(posedge sys_clk);
         cyc++;
         k = key_filter;
         if (!sys_rst_n) begin
            phase = 0;
            prev  = 1'b1;
         end else begin
            pr   = prev && !k;
            rl   = !prev && k;
            prev = k;
            case (phase)
               0: if (pr) begin
                  phase = 1;
                  t0    = cyc;
               end
               1: if (rl) begin
                  phase = 2;
                  t0    = cyc;
               end else if (cyc - t0 == T_LONG) begin
                  push_ev(cyc, EV_LP);
                  phase = 4;
                  t0    = cyc;
               end
               2: if (pr) begin
                  phase = 3;
                  t0    = cyc;
               end else if (cyc - t0 == T_DCLK) begin
                  push_ev(cyc, EV_SP);
                  phase = 0;
               end
               3: if (rl) begin
                  push_ev(cyc, EV_DC);
                  phase = 0;
               end else if (cyc - t0 == T_LONG) begin
                  push_ev(cyc, EV_LP);
                  phase = 4;
                  t0    = cyc;
               end
               default: if (rl) begin
                  phase = 0;
               end else if (REP_ON && ((cyc - t0) % T_REP == 0)) begin
                  push_ev(cyc, EV_RP);
               end
            endcase
         end
         exp_hold = (phase == 4);
      end
   end

   initial begin : monitor
      logic [3:0] obs;
      logic [3:0] exp_v;
      exp_t       e;
      bit         hreq;
      forever begin
         @(negedge sys_clk);
         obs   = {key_repeat, long_press, double_click, short_press};
         exp_v = 4'b0000;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            if (sys_rst_n) exp_v = e.ev;
         end
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL pulses cyc=%0d got=%b want=%b", cyc, obs, exp_v);
         end
         hreq = sys_rst_n ? exp_hold : 1'b0;
         checks++;
         if (long_hold !== hreq) begin
            failures++;
            $display("FAIL long_hold cyc=%0d got=%b want=%b", cyc, long_hold, hreq);
         end
      end
   end

   task automatic hold(input logic lvl, input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
         key_filter = lvl;
      end
   endtask

   initial begin : stim
      logic lvl;
      int   dur;
      repeat (3) @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b1;
      hold(1'b1, 5);
      // single click
      hold(1'b0, 5);
      hold(1'b1, 25);
      // double click
      hold(1'b0, 5);
      hold(1'b1, 3);
      hold(1'b0, 5);
      hold(1'b1, 25);
      // long press then release
      hold(1'b0, 30);
      hold(1'b1, 25);
      // long hold with repeats
      hold(1'b0, 40);
      hold(1'b1, 25);
      // release on the long terminal count
      hold(1'b0, 20);
      hold(1'b1, 25);
      // second press on the window terminal count
      hold(1'b0, 5);
      hold(1'b1, 10);
      hold(1'b0, 5);
      hold(1'b1, 25);
      // reset while the key is held mid-PRESS1
      hold(1'b0, 8);
      @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b1;
      hold(1'b0, 30);
      hold(1'b1, 25);
      // random gestures
      lvl = 1'b1;
      for (int i = 0; i < 60; i++) begin
         lvl = ~lvl;
         case ($urandom_range(0, 2))
            0:       dur = $urandom_range(1, 6);
            1:       dur = $urandom_range(7, 14);
            default: dur = $urandom_range(15, 45);
         endcase
         hold(lvl, dur);
      end
      hold(1'b1, 40);
      @(negedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
